audio_sample_sequencer: RTL and testbench
=========================================

# audio_sample_sequencer

Per-sample controller for the 10-bit audio path (ADC → processor → DAC/PWM). It generates the sampling tick internally and starts an ADC conversion on each tick. It hands the captured sample to the processor with a valid/done handshake, then issues one load pulse to the DAC and PWM outputs. It replaces free-running tick fan-out to the SPI blocks, so every sample frame runs in a fixed order and is checked for overrun and timeout.

## Interface
Parameters:
- `DIV`, 5000: sysclk cycles per sample period (10 kHz at 50 MHz); legal range 16..65535.
- `ADC_TIMEOUT`, 1023: maximum cycles to wait for `adc_valid` after `adc_start`.
- `PROC_TIMEOUT`, 1023: maximum cycles to wait for `proc_done` after `proc_valid`.

Ports:
- `sysclk` in 1: system clock, 50 MHz.
- `rst_n` in 1: reset, asynchronous, active-low.
- `enable` in 1: when high, sample ticks are generated.
- `clr_flags` in 1: single-cycle pulse that clears the sticky flags.
- `adc_start` out 1: one-cycle start pulse to spi2adc.
- `adc_valid` in 1: data_valid from spi2adc.
- `adc_data` in 10: converted sample.
- `proc_valid` out 1: one-cycle pulse; `proc_in` is valid in that cycle.
- `proc_in` out 10: registered sample sent to the processor.
- `proc_done` in 1: one-cycle pulse; `proc_out` is valid in that cycle.
- `proc_out` in 10: processed sample.
- `dac_load` out 1: one-cycle pulse to spi2dac and pwm.
- `dac_data` out 10: registered output sample; holds its value between loads.
- `overrun` out 1: sticky; a tick arrived while a frame was still in progress.
- `timeout` out 1: sticky; the ADC or processor did not respond in time.
- `frame_cnt` out 16: number of completed frames; wraps 65535 → 0.

## Operation
- The period counter counts 0..DIV-1 while `enable`=1. `tick` is asserted when the count equals DIV-1. When `enable`=0, the counter is held at 0 and no ticks occur, but a frame already in progress runs to completion.
- FSM states: IDLE, ADC_REQ, ADC_WAIT, PROC_REQ, PROC_WAIT, DAC_LOAD.
- IDLE: on `tick`, go to ADC_REQ.
- ADC_REQ: `adc_start`=1 for one cycle, then go to ADC_WAIT.
- ADC_WAIT: on `adc_valid`, latch `adc_data` into `proc_in` and go to PROC_REQ. If the wait counter reaches ADC_TIMEOUT, set `timeout`, leave `proc_in` unchanged, and go to DAC_LOAD, which re-sends the previous `dac_data`.
- PROC_REQ: `proc_valid`=1 for one cycle, then go to PROC_WAIT.
- PROC_WAIT: on `proc_done`, latch `proc_out` into `dac_data` and go to DAC_LOAD. On PROC_TIMEOUT, set `timeout`, leave `dac_data` unchanged, and go to DAC_LOAD.
- DAC_LOAD: `dac_load`=1 for one cycle, increment `frame_cnt`, return to IDLE.
- A `tick` in any state other than IDLE sets `overrun`. The tick is dropped and not queued.
- `adc_valid` or `proc_done` arriving outside its wait state is ignored.
- If a handshake input arrives in the same cycle as its timeout, the handshake wins and `timeout` is not set.
- If `clr_flags` coincides with a new flag event, the set wins.

## Timing
- Reset values: all outputs are 0, the FSM is in IDLE, and the period and wait counters are 0. A reset in the middle of a frame aborts it immediately with no `dac_load`.
- `tick` at cycle T → `adc_start` at T+1.
- `adc_valid` at cycle A → `proc_valid` with the new `proc_in` at A+1.
- `proc_done` at cycle P → `dac_load` with the new `dac_data` at P+1; `frame_cnt` updates at P+2.
- The wait counters reset on entry to each wait state. A timeout fires on the cycle the counter equals the limit, i.e. limit+1 cycles after the request pulse.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- First tick after reset with `enable`=1: the period counter starts counting in the first cycle after `rst_n` deasserts, so `tick` occurs at cycle DIV-1 after release.

## Structure
- Shared package `audio_seq_pkg` holds:
  - the state enum;
  - `SAMPLE_W`=10;
  - `CNT_W`=16.
- One sub-module, `sample_tick_gen`, generates the period count/tick with `enable`. The FSM, wait counter, flags and data registers stay in the top module.

## Test plan
- Normal frame, DIV=20: ADC responds 5 cycles after `adc_start` with 0x155, processor returns 0x2AA 3 cycles after `proc_valid` → `proc_in`=0x155, `dac_data`=0x2AA, exactly one `dac_load` per 20 cycles, `frame_cnt` increments by 1 per frame, no flags set.
- ADC timeout, ADC_TIMEOUT=8: no `adc_valid` is driven → `timeout`=1 at `adc_start`+9, `dac_load` is issued with the previous `dac_data`, and no `proc_valid` occurs.
- Overrun, DIV=20: processor delays `proc_done` by 30 cycles → `overrun`=1, the next frame starts on the first tick after return to IDLE, and `frame_cnt` counts only completed frames.
- Clear/set collision: `clr_flags` in the same cycle as a timeout → `timeout` reads 1 afterwards; a lone `clr_flags` → both flags read 0.
- Reset in PROC_WAIT: assert `rst_n`=0 → all outputs are 0 within the same cycle, and there is no `dac_load` for the aborted frame.
- Enable/wrap: `enable` dropped during ADC_WAIT → the frame completes and no further `adc_start` occurs; with `frame_cnt` preloaded via 65535 frames (or forced), the next frame wraps it to 0.

Source files
------------

// File: rtl/audio_seq_pkg.sv
// Shared types and widths for the audio sample sequencer.
// Sample width, frame-counter width and the per-frame FSM state encoding.
package audio_seq_pkg;

    localparam int SAMPLE_W = 10;
    localparam int CNT_W    = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADC_REQ,
        ST_ADC_WAIT,
        ST_PROC_REQ,
        ST_PROC_WAIT,
        ST_DAC_LOAD
    } seq_state_t;

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-period counter: counts 0..DIV-1 while enabled and flags the last count.
// Disabling holds the count at 0 so the next period starts cleanly on re-enable.
module sample_tick_gen
    import audio_seq_pkg::*;
#(
    parameter int DIV = 5000
) (
    input  logic sysclk,
    input  logic rst_n,
    input  logic enable,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] period_cnt;

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            period_cnt <= '0;
        end else if (!enable || period_cnt == LAST_CNT) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + CNT_W'(1);
        end
    end

    assign tick = enable && (period_cnt == LAST_CNT);

endmodule

// File: rtl/audio_sample_sequencer.sv
// Per-sample frame controller: ADC conversion -> processor handshake -> DAC/PWM load,
// with sticky overrun/timeout flags and a completed-frame counter.
//
//   state        | meaning
//   -------------+---------------------------------------------------------
//   ST_IDLE      | waiting for the next sample tick
//   ST_ADC_REQ   | adc_start pulse; ADC wait timer loaded
//   ST_ADC_WAIT  | waiting for adc_valid or ADC timeout
//   ST_PROC_REQ  | proc_valid pulse with the new sample; proc timer loaded
//   ST_PROC_WAIT | waiting for proc_done or processor timeout
//   ST_DAC_LOAD  | dac_load pulse; frame counted
module audio_sample_sequencer
    import audio_seq_pkg::*;
#(
    parameter int DIV          = 5000,
    parameter int ADC_TIMEOUT  = 1023,
    parameter int PROC_TIMEOUT = 1023
) (
    input  logic                sysclk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                clr_flags,
    output logic                adc_start,
    input  logic                adc_valid,
    input  logic [SAMPLE_W-1:0] adc_data,
    output logic                proc_valid,
    output logic [SAMPLE_W-1:0] proc_in,
    input  logic                proc_done,
    input  logic [SAMPLE_W-1:0] proc_out,
    output logic                dac_load,
    output logic [SAMPLE_W-1:0] dac_data,
    output logic                overrun,
    output logic                timeout,
    output logic [CNT_W-1:0]    frame_cnt
);

    localparam logic [CNT_W-1:0] ADC_LIMIT  = CNT_W'(ADC_TIMEOUT);
    localparam logic [CNT_W-1:0] PROC_LIMIT = CNT_W'(PROC_TIMEOUT);

    seq_state_t       state;
    seq_state_t       state_next;
    logic             tick;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] frame_cnt_q;
    logic             adc_take;
    logic             proc_take;
    logic             tmo_hit;
    logic             ovr_hit;

    sample_tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .enable (enable),
        .tick   (tick)
    );

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A handshake arriving on the terminal count takes priority over the timeout.
    always_comb begin
        state_next = state;
        adc_take   = 1'b0;
        proc_take  = 1'b0;
        tmo_hit    = 1'b0;
        case (state)
            ST_IDLE:      if (tick) state_next = ST_ADC_REQ;
            ST_ADC_REQ:   state_next = ST_ADC_WAIT;
            ST_ADC_WAIT: begin
                if (adc_valid) begin
                    adc_take   = 1'b1;
                    state_next = ST_PROC_REQ;
                end else if (wait_cnt == '0) begin
                    tmo_hit    = 1'b1;
                    state_next = ST_DAC_LOAD;
                end
            end
            ST_PROC_REQ:  state_next = ST_PROC_WAIT;
            ST_PROC_WAIT: begin
                if (proc_done) begin
                    proc_take  = 1'b1;
                    state_next = ST_DAC_LOAD;
                end else if (wait_cnt == '0) begin
                    tmo_hit    = 1'b1;
                    state_next = ST_DAC_LOAD;
                end
            end
            ST_DAC_LOAD:  state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    assign ovr_hit = tick && (state != ST_IDLE);

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == ST_ADC_REQ) begin
            wait_cnt <= ADC_LIMIT;
        end else if (state == ST_PROC_REQ) begin
            wait_cnt <= PROC_LIMIT;
        end else if ((state == ST_ADC_WAIT || state == ST_PROC_WAIT) && wait_cnt != '0) begin
            wait_cnt <= wait_cnt - CNT_W'(1);
        end
    end

    // Strobes are decoded from the next state so they line up with the state itself.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            adc_start   <= 1'b0;
            proc_valid  <= 1'b0;
            dac_load    <= 1'b0;
            proc_in     <= '0;
            dac_data    <= '0;
            overrun     <= 1'b0;
            timeout     <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            adc_start   <= (state_next == ST_ADC_REQ);
            proc_valid  <= (state_next == ST_PROC_REQ);
            dac_load    <= (state_next == ST_DAC_LOAD);
            frame_cnt_q <= frame_cnt_q + CNT_W'(dac_load);
            if (adc_take) begin
                proc_in <= adc_data;
            end
            if (proc_take) begin
                dac_data <= proc_out;
            end
            if (ovr_hit) begin
                overrun <= 1'b1;
            end else if (clr_flags) begin
                overrun <= 1'b0;
            end
            if (tmo_hit) begin
                timeout <= 1'b1;
            end else if (clr_flags) begin
                timeout <= 1'b0;
            end
        end
    end

    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_audio_sample_sequencer.sv
// Directed/randomised frame bench for audio_sample_sequencer with a frame-level timing model.
module tb_audio_sample_sequencer;

    localparam int DIV  = 20;
    localparam int ALIM = 8;
    localparam int PLIM = 40;

    logic        sysclk     = 1'b0;
    logic        rst_n      = 1'b0;
    logic        enable     = 1'b0;
    logic        clr_flags  = 1'b0;
    logic        adc_start;
    logic        adc_valid  = 1'b0;
    logic [9:0]  adc_data   = '0;
    logic        proc_valid;
    logic [9:0]  proc_in;
    logic        proc_done  = 1'b0;
    logic [9:0]  proc_out   = '0;
    logic        dac_load;
    logic [9:0]  dac_data;
    logic        overrun;
    logic        timeout;
    logic [15:0] frame_cnt;

    audio_sample_sequencer #(
        .DIV          (DIV),
        .ADC_TIMEOUT  (ALIM),
        .PROC_TIMEOUT (PLIM)
    ) dut (
        .sysclk     (sysclk),
        .rst_n      (rst_n),
        .enable     (enable),
        .clr_flags  (clr_flags),
        .adc_start  (adc_start),
        .adc_valid  (adc_valid),
        .adc_data   (adc_data),
        .proc_valid (proc_valid),
        .proc_in    (proc_in),
        .proc_done  (proc_done),
        .proc_out   (proc_out),
        .dac_load   (dac_load),
        .dac_data   (dac_data),
        .overrun    (overrun),
        .timeout    (timeout),
        .frame_cnt  (frame_cnt)
    );

    initial forever #5 sysclk = ~sysclk;

    int cyc = 0;
    initial forever begin
        @(posedge sysclk);
        cyc++;
    end

    // responder settings: latency 0 means "never answer"
    int         adc_lat  = 0;
    logic [9:0] adc_val  = '0;
    int         proc_lat = 0;
    logic [9:0] proc_val = '0;

    int         q_as[$];
    int         q_pv_c[$];
    logic [9:0] q_pv_d[$];
    int         q_dl_c[$];
    logic [9:0] q_dl_d[$];

    int tests = 0;
    int fails = 0;

    logic [9:0]  m_proc_in = '0;
    logic [9:0]  m_dac     = '0;
    logic [15:0] m_cnt     = '0;
    logic        m_tmo     = 1'b0;
    logic        m_ovr     = 1'b0;
    int          next_tick = 0;

    initial begin : adc_resp
        int cnt;
        cnt = -1;
        forever begin
            @(negedge sysclk);
            adc_valid = 1'b0;
            adc_data  = 10'($urandom);
            if (!rst_n) begin
                cnt = -1;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        adc_valid = 1'b1;
                        adc_data  = adc_val;
                        cnt       = -1;
                    end
                end
                if (adc_start === 1'b1 && adc_lat > 0) cnt = adc_lat;
            end
        end
    end

    initial begin : proc_resp
        int cnt;
        cnt = -1;
        forever begin
            @(negedge sysclk);
            proc_done = 1'b0;
            proc_out  = 10'($urandom);
            if (!rst_n) begin
                cnt = -1;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        proc_done = 1'b1;
                        proc_out  = proc_val;
                        cnt       = -1;
                    end
                end
                if (proc_valid === 1'b1 && proc_lat > 0) cnt = proc_lat;
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge sysclk);
            if (adc_start === 1'b1) q_as.push_back(cyc);
            if (proc_valid === 1'b1) begin
                q_pv_c.push_back(cyc);
                q_pv_d.push_back(proc_in);
            end
            if (dac_load === 1'b1) begin
                q_dl_c.push_back(cyc);
                q_dl_d.push_back(dac_data);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge sysclk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " adc_start"},  32'(adc_start),  32'(0));
        chk({tag, " proc_valid"}, 32'(proc_valid), 32'(0));
        chk({tag, " dac_load"},   32'(dac_load),   32'(0));
        chk({tag, " proc_in"},    32'(proc_in),    32'(0));
        chk({tag, " dac_data"},   32'(dac_data),   32'(0));
        chk({tag, " overrun"},    32'(overrun),    32'(0));
        chk({tag, " timeout"},    32'(timeout),    32'(0));
        chk({tag, " frame_cnt"},  32'(frame_cnt),  32'(0));
    endtask

    // One frame from the predicted tick: derive every event cycle from the latencies,
    // run to the cycle after dac_load, then compare the recorded events and outputs.
    task automatic run_frame(input int a_lat_i, input logic [9:0] a_v, input int p_lat_i,
                             input logic [9:0] p_v, input int clr_off, input bit drop_en,
                             input string tag);
        int t, r, v, l, dt, c, got, ovr_last;
        bit a_ok, p_ok, ovr_any;
        t = next_tick;
        r = t + 1;
        adc_lat = a_lat_i; adc_val = a_v; proc_lat = p_lat_i; proc_val = p_v;
        a_ok = (a_lat_i >= 1) && (a_lat_i <= ALIM + 1);
        p_ok = (p_lat_i >= 1) && (p_lat_i <= PLIM + 1);
        v  = -1;
        dt = -1;
        if (a_ok) begin
            v = r + a_lat_i + 1;
            if (p_ok) l = v + p_lat_i + 1;
            else begin l = v + PLIM + 2; dt = l - 1; end
        end else begin
            l  = r + ALIM + 2;
            dt = l - 1;
        end
        c = (clr_off >= 0) ? r + clr_off : -1;

        while (cyc < l + 1) begin
            step();
            clr_flags = (cyc == c);
            if (drop_en && cyc == r + 2) enable = 1'b0;
        end

        ovr_any  = !drop_en && (t + DIV <= l);
        ovr_last = t + ((l - t) / DIV) * DIV;
        m_tmo = ((c >= 0) ? 1'b0 : m_tmo) | ((dt >= 0) && (dt >= c));
        m_ovr = ((c >= 0) ? 1'b0 : m_ovr) | (ovr_any && (ovr_last >= c));
        if (a_ok) m_proc_in = a_v;
        if (a_ok && p_ok) m_dac = p_v;
        m_cnt = m_cnt + 16'd1;

        chk({tag, " adc_start count"}, 32'(q_as.size()), 32'(1));
        got = (q_as.size() > 0) ? q_as.pop_front() : -1;
        chk({tag, " adc_start cycle"}, 32'(got), 32'(r));
        chk({tag, " proc_valid count"}, 32'(q_pv_c.size()), 32'(a_ok ? 1 : 0));
        if (a_ok && q_pv_c.size() > 0) begin
            chk({tag, " proc_valid cycle"}, 32'(q_pv_c[0]), 32'(v));
            chk({tag, " proc_valid data"},  32'(q_pv_d[0]), 32'(a_v));
        end
        chk({tag, " dac_load count"}, 32'(q_dl_c.size()), 32'(1));
        if (q_dl_c.size() > 0) begin
            chk({tag, " dac_load cycle"}, 32'(q_dl_c[0]), 32'(l));
            chk({tag, " dac_load data"},  32'(q_dl_d[0]), 32'(m_dac));
        end
        chk({tag, " proc_in"},   32'(proc_in),   32'(m_proc_in));
        chk({tag, " dac_data"},  32'(dac_data),  32'(m_dac));
        chk({tag, " frame_cnt"}, 32'(frame_cnt), 32'(m_cnt));
        chk({tag, " timeout"},   32'(timeout),   32'(m_tmo));
        chk({tag, " overrun"},   32'(overrun),   32'(m_ovr));
        q_as.delete(); q_pv_c.delete(); q_pv_d.delete(); q_dl_c.delete(); q_dl_d.delete();

        if (drop_en) next_tick = -1;
        else next_tick = t + ((l + 1 - t + DIV - 1) / DIV) * DIV;
    endtask

    initial begin : main
        int t, v;
        rst_n  = 1'b0;
        enable = 1'b1;
        repeat (3) step();
        chk_zero("reset");
        rst_n     = 1'b1;
        next_tick = cyc + DIV - 1;

        run_frame(5, 10'h155, 3, 10'h2AA, -1, 1'b0, "normal0");
        run_frame(5, 10'h155, 3, 10'h2AA, -1, 1'b0, "normal1");
        for (int i = 0; i < 6; i++) begin
            run_frame(int'($urandom_range(ALIM + 1, 1)), 10'($urandom),
                      int'($urandom_range(12, 1)), 10'($urandom), -1, 1'b0, "rand");
        end
        run_frame(ALIM + 1, 10'($urandom), PLIM + 1, 10'($urandom), -1, 1'b0, "edge_hs");
        run_frame(0, 10'($urandom), 3, 10'($urandom), -1, 1'b0, "adc_tmo");
        run_frame(ALIM + 2, 10'($urandom), 3, 10'($urandom), -1, 1'b0, "adc_late");
        run_frame(5, 10'($urandom), 30, 10'($urandom), -1, 1'b0, "overrun");
        run_frame(4, 10'($urandom), 2, 10'($urandom), -1, 1'b0, "after_ovr");
        run_frame(0, 10'($urandom), 3, 10'($urandom), ALIM + 1, 1'b0, "clr_collide");
        run_frame(5, 10'($urandom), 3, 10'($urandom), 3, 1'b0, "clr_lone");
        run_frame(2, 10'($urandom), 0, 10'($urandom), -1, 1'b0, "proc_tmo");

        run_frame(5, 10'($urandom), 3, 10'($urandom), -1, 1'b1, "en_drop");
        repeat (3 * DIV) step();
        chk("en_drop idle adc_start", 32'(q_as.size()), 32'(0));
        chk("en_drop idle frame_cnt", 32'(frame_cnt), 32'(m_cnt));
        enable    = 1'b1;
        next_tick = cyc + DIV - 1;

        force dut.frame_cnt_q = 16'hFFFF;
        step();
        release dut.frame_cnt_q;
        m_cnt = 16'hFFFF;
        step();
        chk("wrap preload", 32'(frame_cnt), 32'(m_cnt));
        run_frame(3, 10'($urandom), 4, 10'($urandom), -1, 1'b0, "wrap");

        t = next_tick;
        adc_lat = 4; adc_val = 10'h0F0; proc_lat = 30; proc_val = 10'h333;
        v = t + 1 + 4 + 1;
        while (cyc < v + 10) step();
        chk("rst_mid proc_valid seen", 32'(q_pv_c.size()), 32'(1));
        rst_n = 1'b0;
        #1;
        chk_zero("rst_mid");
        repeat (3) step();
        chk("rst_mid no dac_load", 32'(q_dl_c.size()), 32'(0));
        q_as.delete(); q_pv_c.delete(); q_pv_d.delete(); q_dl_c.delete(); q_dl_d.delete();
        m_proc_in = '0; m_dac = '0; m_cnt = '0; m_tmo = 1'b0; m_ovr = 1'b0;
        rst_n     = 1'b1;
        next_tick = cyc + DIV - 1;
        run_frame(5, 10'($urandom), 3, 10'($urandom), -1, 1'b0, "post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
